fb_block_writer: RTL and testbench
==================================

Name: fb_block_writer

Overview:
- Producer for the SDRAM controller's FIFO write side (WR / WR_DATA / WR_FULL) in the Tetris framebuffer path.
- Accepts "paint block" or "clear screen" commands from game logic and streams one RGB565 word per pixel, with its linear framebuffer word address.
- Honours FIFO backpressure and clips off-screen pixels.
- The VGA scan-out side reads the same buffer back.

Parameters:
- H_RES, 640, visible pixels per line; also the address stride per row.
- V_RES, 480, visible lines.
- BLOCK_SIZE, 16, edge length in pixels of one Tetris cell.
- ADDR_W, 19, framebuffer word-address width (must satisfy 2^ADDR_W >= H_RES*V_RES).

Ports:
- Clk, input, 1: system clock; single clock domain, shared with the FIFO write clock.
- Reset, input, 1: asynchronous, active-high reset.
- cmd_valid, input, 1: command present.
- cmd_ready, output, 1: high only in IDLE; a command is accepted on cmd_valid && cmd_ready.
- cmd_clear, input, 1: 1 = fill the whole screen; cmd_x and cmd_y are ignored.
- cmd_x, input, 10: block top-left X in pixels.
- cmd_y, input, 10: block top-left Y in pixels.
- cmd_color, input, 16: RGB565 fill colour.
- wr_full, input, 1: FIFO full flag from the SDRAM controller.
- wr_req, output, 1: write strobe; one word is consumed on every cycle it is high.
- wr_data, output, 16: pixel colour.
- wr_addr, output, ADDR_W: linear word address = y*H_RES + x.
- busy, output, 1: state != IDLE.
- done, output, 1: one-cycle pulse when a command completes.

Behaviour:
- Reset values: state=IDLE, cmd_ready=1, wr_req=0, wr_data=0, wr_addr=0, busy=0, done=0, all counters 0. Reset takes effect asynchronously at any time, including mid-command; the in-flight command is abandoned with no further writes.
- State IDLE: cmd_ready=1.
  - On accept, latch the colour.
  - Block command: origin=(cmd_x,cmd_y), width=height=BLOCK_SIZE.
  - Clear command: origin=(0,0), width=H_RES, height=V_RES.
  - Set col=0, row=0, line_addr=origin_y*H_RES+origin_x, then go to WRITE.
  - cmd_valid while not in IDLE is ignored (not queued).
- State WRITE: the current pixel is (origin_x+col, origin_y+row).
  - in_bounds = (origin_x+col < H_RES) && (origin_y+row < V_RES). Compare with at least 11 bits so no wrap.
  - wr_req = in_bounds && !wr_full. This is combinational from registered state and wr_full.
  - wr_data = latched colour. wr_addr = line_addr + col, a registered or register-derived value stable while stalled.
  - Advance condition is !wr_full, regardless of in_bounds. Clipped pixels still advance, using one cycle each with no write.
  - On advance: col++. When col reaches width-1, col wraps to 0, row++, and line_addr += H_RES. The row stride addition replaces any multiply after the accept cycle.
  - On advancing past (width-1, height-1), go to DONE.
  - While wr_full=1: hold all counters and hold wr_addr/wr_data. wr_req stays 0.
- State DONE: done=1, cmd_ready=0 for exactly one cycle, then IDLE.
- Timing, unclipped block with wr_full=0 and accept at cycle N:
  - writes at N+1 .. N+BLOCK_SIZE^2;
  - done at N+BLOCK_SIZE^2+1;
  - cmd_ready at N+BLOCK_SIZE^2+2.
- Each stalled cycle adds exactly one cycle of latency.
- Pixel order is row-major, increasing addresses within a row.
- The accept-cycle multiply (origin_y*H_RES) may use constant shift-and-add (640 = 512+128).
- Width rules: wr_addr wraps modulo 2^ADDR_W. Callers never present such addresses because out-of-range pixels are clipped.

Decomposition:
- Shared package fb_pkg holds:
  - constants H_RES, V_RES, BLOCK_SIZE, FB_ADDR_W;
  - typedef rgb565_t (16-bit);
  - enum fbw_state_t {IDLE, WRITE, DONE}.
- One natural sub-module, fb_raster_counter: col/row counters plus line_addr accumulator with advance, last and in_bounds outputs. It is reusable by the scan-out reader.

Test Plan:
- Basic block: BLOCK_SIZE=16, cmd (x=32,y=48,color=16'hF800), wr_full=0.
  - Exactly 256 writes.
  - First wr_addr=48*640+32=30752. Address 30767 is followed by 31392.
  - Last wr_addr=63*640+47=40367.
  - done one cycle after the last write; cmd_ready two cycles after it.
- Backpressure: same command with wr_full high for 5 cycles starting at the 10th write.
  - No wr_req while full; wr_addr held at 30761.
  - Still exactly 256 writes, no duplicates or gaps.
  - done is 5 cycles later than in the basic case.
- Clipping: cmd (x=632,y=472), 16x16.
  - Only x 632..639 and y 472..479 written: 64 writes, last addr 479*640+639=307199.
  - done after 256 advance cycles (+1).
- Clear: cmd_clear=1, color=16'h0000.
  - 307200 writes, addresses 0..307199 contiguous.
  - busy high throughout; done pulses once.
- Reset mid-command: assert Reset after 100 writes of a block command.
  - wr_req=0 immediately, cmd_ready=1 after release.
  - A new command starts from its own origin with no stale counters.
- Ignored command: pulse cmd_valid with a different origin while busy.
  - Not accepted.
  - Write stream unchanged; only the first command's 256 addresses appear.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, pixel type and block-writer state encoding.
package fb_pkg;

  localparam int unsigned H_RES      = 640;
  localparam int unsigned V_RES      = 480;
  localparam int unsigned BLOCK_SIZE = 16;
  localparam int unsigned FB_ADDR_W  = 19;
  localparam int unsigned COORD_W    = 11;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } fbw_state_t;

endpackage

// File: rtl/fb_raster_counter.sv
// Row-major raster walker over a rectangle: col/row counters, a line-address
// accumulator (row stride added, never multiplied) and an on-screen flag.
module fb_raster_counter
  import fb_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [COORD_W-1:0]   i_origin_x,
  input  logic [COORD_W-1:0]   i_origin_y,
  input  logic [COORD_W-1:0]   i_width,
  input  logic [COORD_W-1:0]   i_height,
  input  logic                 i_advance,
  output logic [FB_ADDR_W-1:0] o_addr,
  output logic                 o_last,
  output logic                 o_in_bounds
);

  localparam int unsigned PX_W = COORD_W + 1;

  logic [COORD_W-1:0]   r_org_x;
  logic [COORD_W-1:0]   r_org_y;
  logic [COORD_W-1:0]   r_width;
  logic [COORD_W-1:0]   r_height;
  logic [COORD_W-1:0]   r_col;
  logic [COORD_W-1:0]   r_row;
  logic [FB_ADDR_W-1:0] r_line_addr;

  logic                 w_col_last;
  logic                 w_row_last;
  logic [PX_W-1:0]      w_px;
  logic [PX_W-1:0]      w_py;
  logic [FB_ADDR_W-1:0] w_start_addr;

  assign w_col_last   = (r_col == r_width - COORD_W'(1));
  assign w_row_last   = (r_row == r_height - COORD_W'(1));
  assign w_px         = PX_W'(r_org_x) + PX_W'(r_col);
  assign w_py         = PX_W'(r_org_y) + PX_W'(r_row);
  // Only multiply in the design; H_RES is a constant so this folds to shift-and-add.
  assign w_start_addr = FB_ADDR_W'(i_origin_y) * FB_ADDR_W'(H_RES) + FB_ADDR_W'(i_origin_x);

  assign o_addr      = r_line_addr + FB_ADDR_W'(r_col);
  assign o_last      = w_col_last && w_row_last;
  assign o_in_bounds = (w_px < PX_W'(H_RES)) && (w_py < PX_W'(V_RES));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_org_x     <= '0;
      r_org_y     <= '0;
      r_width     <= '0;
      r_height    <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_line_addr <= '0;
    end else if (i_start) begin
      r_org_x     <= i_origin_x;
      r_org_y     <= i_origin_y;
      r_width     <= i_width;
      r_height    <= i_height;
      r_col       <= '0;
      r_row       <= '0;
      r_line_addr <= w_start_addr;
    end else if (i_advance) begin
      if (w_col_last) begin
        r_col       <= '0;
        r_row       <= r_row + COORD_W'(1);
        r_line_addr <= r_line_addr + FB_ADDR_W'(H_RES);
      end else begin
        r_col <= r_col + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/fb_block_writer.sv
// Paints a Tetris cell or clears the screen by streaming RGB565 words with
// their framebuffer addresses into the SDRAM controller write FIFO.
module fb_block_writer
  import fb_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic                 i_cmd_clear,
  input  logic [9:0]           i_cmd_x,
  input  logic [9:0]           i_cmd_y,
  input  logic [15:0]          i_cmd_color,
  input  logic                 i_wr_full,
  output logic                 o_wr_req,
  output logic [15:0]          o_wr_data,
  output logic [FB_ADDR_W-1:0] o_wr_addr,
  output logic                 o_busy,
  output logic                 o_done
);

  fbw_state_t         r_state;
  fbw_state_t         w_next;
  rgb565_t            r_color;

  logic               w_start;
  logic               w_advance;
  logic               w_last;
  logic               w_in_bounds;
  logic [COORD_W-1:0] w_org_x;
  logic [COORD_W-1:0] w_org_y;
  logic [COORD_W-1:0] w_width;
  logic [COORD_W-1:0] w_height;

  // A clear is just a full-screen rectangle anchored at the origin.
  always_comb begin
    w_org_x  = i_cmd_clear ? '0 : COORD_W'(i_cmd_x);
    w_org_y  = i_cmd_clear ? '0 : COORD_W'(i_cmd_y);
    w_width  = i_cmd_clear ? COORD_W'(H_RES) : COORD_W'(BLOCK_SIZE);
    w_height = i_cmd_clear ? COORD_W'(V_RES) : COORD_W'(BLOCK_SIZE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_cmd_valid)           w_next = WRITE;
      WRITE:   if (!i_wr_full && w_last)  w_next = DONE;
      DONE:                               w_next = IDLE;
      default:                            w_next = IDLE;
    endcase
  end

  // Clipped pixels still consume an advance cycle, they just never strobe.
  always_comb begin
    o_cmd_ready = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    o_wr_req    = 1'b0;
    w_start     = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        o_cmd_ready = 1'b1;
        o_busy      = 1'b0;
        w_start     = i_cmd_valid;
      end
      WRITE: begin
        o_wr_req  = w_in_bounds && !i_wr_full;
        w_advance = !i_wr_full;
      end
      DONE:    o_done = 1'b1;
      default: o_busy = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_color <= '0;
    else if (w_start) r_color <= i_cmd_color;
  end

  assign o_wr_data = r_color;

  fb_raster_counter u_raster (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (w_start),
    .i_origin_x  (w_org_x),
    .i_origin_y  (w_org_y),
    .i_width     (w_width),
    .i_height    (w_height),
    .i_advance   (w_advance),
    .o_addr      (o_wr_addr),
    .o_last      (w_last),
    .o_in_bounds (w_in_bounds)
  );

endmodule

// File: tb/tb_fb_block_writer.sv
// Directed bench for fb_block_writer: block paint, backpressure, clipping,
// ignored commands, reset mid-command and a partial screen clear.
module tb_fb_block_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_clear = 1'b0;
  logic [9:0]  cmd_x = '0;
  logic [9:0]  cmd_y = '0;
  logic [15:0] cmd_color = '0;
  logic        wr_full = 1'b0;
  logic        wr_req;
  logic [15:0] wr_data;
  logic [18:0] wr_addr;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  int got_addr[$];
  int exp_addr[$];

  int s_first, s_last, s_done_cyc, s_ready_cyc, s_done_cnt, s_busy_low;
  int s_data_bad, s_stall_req, s_stall_addr, s_stall_chg, s_ign_ready;
  bit s_timeout, s_acc_ready;

  always #5 clk = ~clk;

  fb_block_writer dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_clear (cmd_clear),
    .i_cmd_x     (cmd_x),
    .i_cmd_y     (cmd_y),
    .i_cmd_color (cmd_color),
    .i_wr_full   (wr_full),
    .o_wr_req    (wr_req),
    .o_wr_data   (wr_data),
    .o_wr_addr   (wr_addr),
    .o_busy      (busy),
    .o_done      (done)
  );

  function automatic int ga(input int i);
    return (i < got_addr.size()) ? got_addr[i] : -1;
  endfunction

  function automatic int seq_mismatch();
    int bad = 0;
    for (int i = 0; i < exp_addr.size(); i++)
      if (ga(i) != exp_addr[i]) bad++;
    if (got_addr.size() > exp_addr.size()) bad += got_addr.size() - exp_addr.size();
    return bad;
  endfunction

  // Expected row-major, clipped address list of a w x h rectangle.
  task automatic build_model(input int x, input int y, input int w, input int h);
    exp_addr.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if (x + c < 640 && y + r < 480) exp_addr.push_back((y + r) * 640 + x + c);
  endtask

  // Issues one command, then records the write stream cycle by cycle.
  // Cycle 1 is the first cycle after the accept edge.
  task automatic run_stream(input logic clr, input int x, input int y, input logic [15:0] color,
                            input int stall_at, input int stall_len, input int ign_at,
                            input int abort_after, input int max_cyc);
    bit aborted = 0;
    got_addr.delete();
    s_first = 0; s_last = 0; s_done_cyc = 0; s_ready_cyc = 0; s_done_cnt = 0;
    s_busy_low = 0; s_data_bad = 0; s_stall_req = 0; s_stall_addr = -1;
    s_stall_chg = 0; s_ign_ready = 0; s_timeout = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_clear = clr; cmd_x = 10'(x); cmd_y = 10'(y);
    cmd_color = color; wr_full = 1'b0;
    #1 s_acc_ready = cmd_ready;
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge clk); #1;
      cmd_valid = (ign_at > 0 && c >= ign_at && c < ign_at + 3);
      cmd_clear = 1'b0;
      if (cmd_valid) begin
        cmd_x = 10'(x + 7); cmd_y = 10'(y + 9); cmd_color = ~color;
      end
      wr_full = (stall_len > 0 && c >= stall_at && c < stall_at + stall_len);
      #1;
      if (wr_full) begin
        if (wr_req) s_stall_req++;
        if (c == stall_at) s_stall_addr = int'(wr_addr);
        else if (int'(wr_addr) != s_stall_addr) s_stall_chg++;
      end
      if (cmd_valid && cmd_ready) s_ign_ready++;
      if (wr_req) begin
        got_addr.push_back(int'(wr_addr));
        if (wr_data !== color) s_data_bad++;
        if (s_first == 0) s_first = c;
        s_last = c;
      end
      if (done) begin
        s_done_cnt++;
        if (s_done_cyc == 0) s_done_cyc = c;
      end
      if (busy === cmd_ready) s_busy_low++;
      if (cmd_ready) begin
        s_ready_cyc = c;
        break;
      end
      if (abort_after > 0 && got_addr.size() >= abort_after) begin
        aborted = 1;
        break;
      end
    end
    cmd_valid = 1'b0;
    wr_full   = 1'b0;
    if (!aborted && s_ready_cyc == 0) s_timeout = 1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %0b want 1", cmd_ready); end
    n_checks++; if (wr_req !== 1'b0) begin n_fail++; $display("FAIL reset_wr_req got %0b want 0", wr_req); end
    n_checks++; if (wr_data !== 16'h0000) begin n_fail++; $display("FAIL reset_wr_data got %h want 0000", wr_data); end
    n_checks++; if (wr_addr !== 19'd0) begin n_fail++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
    rst = 1'b0;
  endtask

  task automatic test_basic_block();
    run_stream(1'b0, 32, 48, 16'hF800, 0, 0, 0, 0, 400);
    build_model(32, 48, 16, 16);
    n_checks++; if (s_timeout) begin n_fail++; $display("FAIL basic_timeout got 1 want 0"); end
    n_checks++; if (!s_acc_ready) begin n_fail++; $display("FAIL basic_accept_ready got 0 want 1"); end
    n_checks++; if (got_addr.size() != 256) begin n_fail++; $display("FAIL basic_nwrites got %0d want 256", got_addr.size()); end
    n_checks++; if (ga(0) != 30752) begin n_fail++; $display("FAIL basic_first_addr got %0d want 30752", ga(0)); end
    n_checks++; if (ga(15) != 30767) begin n_fail++; $display("FAIL basic_row_end_addr got %0d want 30767", ga(15)); end
    n_checks++; if (ga(16) != 31392) begin n_fail++; $display("FAIL basic_row_wrap_addr got %0d want 31392", ga(16)); end
    n_checks++; if (ga(255) != 40367) begin n_fail++; $display("FAIL basic_last_addr got %0d want 40367", ga(255)); end
    n_checks++; if (seq_mismatch() != 0) begin n_fail++; $display("FAIL basic_addr_seq got %0d mismatches want 0", seq_mismatch()); end
    n_checks++; if (s_data_bad != 0) begin n_fail++; $display("FAIL basic_data got %0d bad words want 0", s_data_bad); end
    n_checks++; if (s_first != 1 || s_last != 256) begin n_fail++; $display("FAIL basic_write_window got %0d..%0d want 1..256", s_first, s_last); end
    n_checks++; if (s_done_cyc != 257) begin n_fail++; $display("FAIL basic_done_cycle got %0d want 257", s_done_cyc); end
    n_checks++; if (s_ready_cyc != 258) begin n_fail++; $display("FAIL basic_ready_cycle got %0d want 258", s_ready_cyc); end
    n_checks++; if (s_done_cnt != 1) begin n_fail++; $display("FAIL basic_done_pulses got %0d want 1", s_done_cnt); end
    n_checks++; if (s_busy_low != 0) begin n_fail++; $display("FAIL basic_busy got %0d bad cycles want 0", s_busy_low); end
  endtask

  task automatic test_backpressure();
    run_stream(1'b0, 32, 48, 16'hF800, 10, 5, 0, 0, 400);
    build_model(32, 48, 16, 16);
    n_checks++; if (s_timeout) begin n_fail++; $display("FAIL bp_timeout got 1 want 0"); end
    n_checks++; if (s_stall_req != 0) begin n_fail++; $display("FAIL bp_req_while_full got %0d want 0", s_stall_req); end
    n_checks++; if (s_stall_addr != 30761) begin n_fail++; $display("FAIL bp_held_addr got %0d want 30761", s_stall_addr); end
    n_checks++; if (s_stall_chg != 0) begin n_fail++; $display("FAIL bp_addr_moved got %0d want 0", s_stall_chg); end
    n_checks++; if (got_addr.size() != 256) begin n_fail++; $display("FAIL bp_nwrites got %0d want 256", got_addr.size()); end
    n_checks++; if (seq_mismatch() != 0) begin n_fail++; $display("FAIL bp_addr_seq got %0d mismatches want 0", seq_mismatch()); end
    n_checks++; if (s_last != 261) begin n_fail++; $display("FAIL bp_last_write_cycle got %0d want 261", s_last); end
    n_checks++; if (s_done_cyc != 262) begin n_fail++; $display("FAIL bp_done_cycle got %0d want 262", s_done_cyc); end
    n_checks++; if (s_ready_cyc != 263) begin n_fail++; $display("FAIL bp_ready_cycle got %0d want 263", s_ready_cyc); end
  endtask

  task automatic test_clipping();
    run_stream(1'b0, 632, 472, 16'h001F, 0, 0, 0, 0, 400);
    build_model(632, 472, 16, 16);
    n_checks++; if (s_timeout) begin n_fail++; $display("FAIL clip_timeout got 1 want 0"); end
    n_checks++; if (got_addr.size() != 64) begin n_fail++; $display("FAIL clip_nwrites got %0d want 64", got_addr.size()); end
    n_checks++; if (ga(0) != 302712) begin n_fail++; $display("FAIL clip_first_addr got %0d want 302712", ga(0)); end
    n_checks++; if (ga(63) != 307199) begin n_fail++; $display("FAIL clip_last_addr got %0d want 307199", ga(63)); end
    n_checks++; if (seq_mismatch() != 0) begin n_fail++; $display("FAIL clip_addr_seq got %0d mismatches want 0", seq_mismatch()); end
    n_checks++; if (s_last != 120) begin n_fail++; $display("FAIL clip_last_write_cycle got %0d want 120", s_last); end
    n_checks++; if (s_done_cyc != 257) begin n_fail++; $display("FAIL clip_done_cycle got %0d want 257", s_done_cyc); end
    n_checks++; if (s_ready_cyc != 258) begin n_fail++; $display("FAIL clip_ready_cycle got %0d want 258", s_ready_cyc); end
  endtask

  task automatic test_ignored_cmd();
    run_stream(1'b0, 32, 48, 16'hABCD, 0, 0, 50, 0, 400);
    build_model(32, 48, 16, 16);
    n_checks++; if (s_ign_ready != 0) begin n_fail++; $display("FAIL ign_ready_while_busy got %0d want 0", s_ign_ready); end
    n_checks++; if (got_addr.size() != 256) begin n_fail++; $display("FAIL ign_nwrites got %0d want 256", got_addr.size()); end
    n_checks++; if (seq_mismatch() != 0) begin n_fail++; $display("FAIL ign_addr_seq got %0d mismatches want 0", seq_mismatch()); end
    n_checks++; if (s_data_bad != 0) begin n_fail++; $display("FAIL ign_data got %0d bad words want 0", s_data_bad); end
    n_checks++; if (s_done_cyc != 257) begin n_fail++; $display("FAIL ign_done_cycle got %0d want 257", s_done_cyc); end
    repeat (3) @(posedge clk);
    #2;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_not_queued busy got %0b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    run_stream(1'b0, 64, 32, 16'h7BEF, 0, 0, 0, 100, 400);
    n_checks++; if (got_addr.size() != 100) begin n_fail++; $display("FAIL rst_pre_writes got %0d want 100", got_addr.size()); end
    rst = 1'b1;
    #1;
    n_checks++; if (wr_req !== 1'b0) begin n_fail++; $display("FAIL rst_async_wr_req got %0b want 0", wr_req); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got %0b want 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got %0b want 1", cmd_ready); end
    n_checks++; if (wr_addr !== 19'd0) begin n_fail++; $display("FAIL rst_counters_addr got %0d want 0", wr_addr); end
    run_stream(1'b0, 200, 100, 16'h07E0, 0, 0, 0, 0, 400);
    build_model(200, 100, 16, 16);
    n_checks++; if (ga(0) != 64200) begin n_fail++; $display("FAIL rst_new_first_addr got %0d want 64200", ga(0)); end
    n_checks++; if (ga(255) != 73815) begin n_fail++; $display("FAIL rst_new_last_addr got %0d want 73815", ga(255)); end
    n_checks++; if (got_addr.size() != 256) begin n_fail++; $display("FAIL rst_new_nwrites got %0d want 256", got_addr.size()); end
    n_checks++; if (seq_mismatch() != 0) begin n_fail++; $display("FAIL rst_new_addr_seq got %0d mismatches want 0", seq_mismatch()); end
    n_checks++; if (s_done_cyc != 257) begin n_fail++; $display("FAIL rst_new_done_cycle got %0d want 257", s_done_cyc); end
  endtask

  // First 40 lines of a clear (x/y inputs must be ignored), then abandoned by reset.
  task automatic test_clear();
    run_stream(1'b1, 100, 100, 16'h0000, 0, 0, 0, 25600, 30000);
    exp_addr.delete();
    for (int i = 0; i < 25600; i++) exp_addr.push_back(i);
    n_checks++; if (got_addr.size() != 25600) begin n_fail++; $display("FAIL clr_nwrites got %0d want 25600", got_addr.size()); end
    n_checks++; if (seq_mismatch() != 0) begin n_fail++; $display("FAIL clr_addr_seq got %0d mismatches want 0", seq_mismatch()); end
    n_checks++; if (s_first != 1 || s_last != 25600) begin n_fail++; $display("FAIL clr_write_window got %0d..%0d want 1..25600", s_first, s_last); end
    n_checks++; if (s_busy_low != 0) begin n_fail++; $display("FAIL clr_busy got %0d bad cycles want 0", s_busy_low); end
    n_checks++; if (s_done_cnt != 0) begin n_fail++; $display("FAIL clr_early_done got %0d want 0", s_done_cnt); end
    n_checks++; if (s_data_bad != 0) begin n_fail++; $display("FAIL clr_data got %0d bad words want 0", s_data_bad); end
    rst = 1'b1;
    #1;
    n_checks++; if (wr_req !== 1'b0) begin n_fail++; $display("FAIL clr_abort_wr_req got %0b want 0", wr_req); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_block();
    test_backpressure();
    test_clipping();
    test_ignored_cmd();
    test_reset_mid();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
